// File: rtl/aes_128_dec_iter.sv
// rtl/aes_128_dec_iter.sv - iterative AES-128 inverse cipher, optional key cache under AES_DEC_KEY_CACHE_EN
module gf256_inv (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
        logic [7:0] p;
        logic [7:0] acc;
        p   = x;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) acc = acc ^ p;
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse and maps 0 to 0
    function automatic logic [7:0] gf_pow254(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    assign y = gf_pow254(a);
endmodule

module sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] b;

    gf256_inv u_inv (.a(a), .y(b));

    assign y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

module inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] b;

    assign b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;

    gf256_inv u_inv (.a(b), .y(y));
endmodule

module aes_128_dec_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext
);
    typedef enum logic [1:0] {IDLE, KEXP, DEC, DONE} state_t;

    state_t       state;
    state_t       state_nx;
    logic [127:0] ct_r;
    logic [127:0] rk;
    logic [127:0] s;
    logic [3:0]   cnt;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9[4];
        logic [7:0] mb[4];
        logic [7:0] md[4];
        logic [7:0] me[4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // byte i of the block lives at bits [127-8i -: 8]; row = i%4, column = i/4
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] x);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = x[127-8*(4*((c+4-r)%4)+r) -: 8];
        return o;
    endfunction

    // One S-box word serves both directions of the key schedule
    logic [31:0]  ks_word;
    logic [31:0]  ks_rot;
    logic [31:0]  ks_sub;
    logic [31:0]  ks_temp;
    logic [127:0] rk_fwd;
    logic [127:0] rk_inv;

    assign ks_word = (state == DEC) ? (rk[63:32] ^ rk[31:0]) : rk[31:0];
    assign ks_rot  = {ks_word[23:0], ks_word[31:24]};
    assign ks_temp = ks_sub ^ {rcon((state == DEC) ? (4'd9 - cnt) : cnt), 24'h0};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_ks_sbox
            sbox u_sbox (.a(ks_rot[31-8*g -: 8]), .y(ks_sub[31-8*g -: 8]));
        end
    endgenerate

    always_comb begin
        rk_fwd[127:96] = rk[127:96] ^ ks_temp;
        rk_fwd[95:64]  = rk[95:64]  ^ rk_fwd[127:96];
        rk_fwd[63:32]  = rk[63:32]  ^ rk_fwd[95:64];
        rk_fwd[31:0]   = rk[31:0]   ^ rk_fwd[63:32];
        rk_inv[31:0]   = rk[31:0]   ^ rk[63:32];
        rk_inv[63:32]  = rk[63:32]  ^ rk[95:64];
        rk_inv[95:64]  = rk[95:64]  ^ rk[127:96];
        rk_inv[127:96] = rk[127:96] ^ ks_temp;
    end

    logic [127:0] sr;
    logic [127:0] isb;
    logic [127:0] t;
    logic [127:0] mixed;

    assign sr = inv_shift_rows(s);

    generate
        for (g = 0; g < 16; g++) begin : g_inv_sbox
            inv_sbox u_inv_sbox (.a(sr[127-8*g -: 8]), .y(isb[127-8*g -: 8]));
        end
    endgenerate

    assign t     = isb ^ rk_inv;
    assign mixed = {inv_mix_col(t[127:96]), inv_mix_col(t[95:64]),
                    inv_mix_col(t[63:32]),  inv_mix_col(t[31:0])};

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] cache_key;
    logic [127:0] cache_rk10;
    logic         cache_vld;
    logic         cache_hit;

    assign cache_hit = cache_vld && (key == cache_key);

    // The key is noted at accept; the entry only becomes valid once KEXP finishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_key  <= '0;
            cache_rk10 <= '0;
            cache_vld  <= 1'b0;
        end else if (state == IDLE && in_valid && !cache_hit) begin
            cache_key <= key;
            cache_vld <= 1'b0;
        end else if (state == KEXP && cnt == 4'd9) begin
            cache_rk10 <= rk_fwd;
            cache_vld  <= 1'b1;
        end
    end
`else
    logic cache_hit;
    assign cache_hit = 1'b0;
`endif

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid)      state_nx = cache_hit ? DEC : KEXP;
            KEXP: if (cnt == 4'd9)   state_nx = DEC;
            DEC:  if (cnt == 4'd9)   state_nx = DONE;
            DONE: if (out_ready)     state_nx = IDLE;
            default:                 state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ct_r      <= '0;
            rk        <= '0;
            s         <= '0;
            cnt       <= '0;
            plaintext <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ct_r <= ciphertext;
                    rk   <= key;
                    cnt  <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
                    if (cache_hit) begin
                        rk <= cache_rk10;
                        s  <= ciphertext ^ cache_rk10;
                    end
`endif
                end
                KEXP: begin
                    rk  <= rk_fwd;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd9) begin
                        s   <= ct_r ^ rk_fwd;
                        cnt <= '0;
                    end
                end
                DEC: begin
                    rk  <= rk_inv;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd9) begin
                        s         <= t;
                        plaintext <= t;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        s <= mixed;
                    end
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
